// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: default sizes, direction
// counter encodings and the saturating counter update.
package branch_target_buffer_pkg;

  localparam int unsigned BTB_ENTRY_NUM = 64;
  localparam int unsigned BTB_XLEN      = 32;
  localparam int unsigned CNT_W         = 2;

  typedef enum logic [CNT_W-1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt_e;

  // Newly allocated entries start weakly taken.
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_WT;

  // Saturating 2-bit direction counter update.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic             taken);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) nxt = cnt + CNT_W'(1);
    end else begin
      if (cnt != CNT_SNT) nxt = cnt - CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_entry_ram.sv
// Tag/target/counter storage: asynchronous lookup read port plus a synchronous
// write port whose addressed entry is also readable for read-modify-write.
module btb_entry_ram
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = BTB_ENTRY_NUM,
  parameter int unsigned TAG_W = 24,
  parameter int unsigned XLEN  = BTB_XLEN
) (
  input  logic                     clk_i,
  input  logic [$clog2(DEPTH)-1:0] lk_addr_i,
  output logic [TAG_W-1:0]         lk_tag_c,
  output logic [XLEN-1:0]          lk_target_c,
  output logic [CNT_W-1:0]         lk_cnt_c,
  input  logic [$clog2(DEPTH)-1:0] tr_addr_i,
  output logic [TAG_W-1:0]         tr_tag_c,
  output logic [XLEN-1:0]          tr_target_c,
  output logic [CNT_W-1:0]         tr_cnt_c,
  input  logic                     tr_we_i,
  input  logic [TAG_W-1:0]         tr_tag_i,
  input  logic [XLEN-1:0]          tr_target_i,
  input  logic [CNT_W-1:0]         tr_cnt_i
);

  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [XLEN-1:0]  target_mem [DEPTH];
  logic [CNT_W-1:0] cnt_mem    [DEPTH];

  always_ff @(posedge clk_i) begin
    if (tr_we_i) begin
      tag_mem[tr_addr_i]    <= tr_tag_i;
      target_mem[tr_addr_i] <= tr_target_i;
      cnt_mem[tr_addr_i]    <= tr_cnt_i;
    end
  end

  assign lk_tag_c    = tag_mem[lk_addr_i];
  assign lk_target_c = target_mem[lk_addr_i];
  assign lk_cnt_c    = cnt_mem[lk_addr_i];

  assign tr_tag_c    = tag_mem[tr_addr_i];
  assign tr_target_c = target_mem[tr_addr_i];
  assign tr_cnt_c    = cnt_mem[tr_addr_i];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: Fetch lookup presented in
// Decode, prediction carried to Execute for misprediction check and training.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = BTB_ENTRY_NUM,
  parameter int unsigned XLEN      = BTB_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_dec_i,
  input  logic            flush_exe_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  input  logic            exe_is_branch_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic            exe_taken_i,
  input  logic [XLEN-1:0] exe_target_i,
  output logic            branch_hit_o,
  output logic            branch_decision_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            branch_misprediction_o
);

  localparam int unsigned IDX   = $clog2(ENTRY_NUM);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  logic [IDX-1:0]   lk_idx, tr_idx;
  logic [TAG_W-1:0] lk_tag, tr_tag;

  assign lk_idx = pc_i[IDX+1:2];
  assign lk_tag = pc_i[XLEN-1:IDX+2];
  assign tr_idx = exe_pc_i[IDX+1:2];
  assign tr_tag = exe_pc_i[XLEN-1:IDX+2];

  // Byte offset within the word never participates in indexing or tagging.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{pc_i[1:0], exe_pc_i[1:0]};

  logic [TAG_W-1:0] ram_lk_tag, ram_tr_tag;
  logic [XLEN-1:0]  ram_lk_target, ram_tr_target;
  logic [CNT_W-1:0] ram_lk_cnt, ram_tr_cnt;

  logic             tr_we;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  logic [CNT_W-1:0] wr_cnt;

  btb_entry_ram #(
    .DEPTH (ENTRY_NUM),
    .TAG_W (TAG_W),
    .XLEN  (XLEN)
  ) u_ram (
    .clk_i       (clk_i),
    .lk_addr_i   (lk_idx),
    .lk_tag_c    (ram_lk_tag),
    .lk_target_c (ram_lk_target),
    .lk_cnt_c    (ram_lk_cnt),
    .tr_addr_i   (tr_idx),
    .tr_tag_c    (ram_tr_tag),
    .tr_target_c (ram_tr_target),
    .tr_cnt_c    (ram_tr_cnt),
    .tr_we_i     (tr_we),
    .tr_tag_i    (wr_tag),
    .tr_target_i (wr_target),
    .tr_cnt_i    (wr_cnt)
  );

  logic [ENTRY_NUM-1:0] valid_q;
  logic                 lk_hit_c;
  logic                 tr_hit_c;

  assign lk_hit_c = pc_valid_i & valid_q[lk_idx] & (ram_lk_tag == lk_tag);
  assign tr_hit_c = valid_q[tr_idx] & (ram_tr_tag == tr_tag);

  // Training: update on tag hit, allocate only on a taken miss.
  always_comb begin
    tr_we     = 1'b0;
    wr_tag    = tr_tag;
    wr_target = ram_tr_target;
    wr_cnt    = ram_tr_cnt;
    if (exe_is_branch_i && !stall_i) begin
      if (tr_hit_c) begin
        tr_we  = 1'b1;
        wr_cnt = cnt_next(ram_tr_cnt, exe_taken_i);
        if (exe_taken_i) wr_target = exe_target_i;
      end else if (exe_taken_i) begin
        tr_we     = 1'b1;
        wr_target = exe_target_i;
        wr_cnt    = CNT_ALLOC;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (tr_we) begin
      valid_q[tr_idx] <= 1'b1;
    end
  end

  logic            hit_d, dec_d, hit_e, dec_e;
  logic [XLEN-1:0] tgt_d, tgt_e;

  // Stage registers; a flush clears even while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_d <= 1'b0;
      dec_d <= 1'b0;
      tgt_d <= '0;
      hit_e <= 1'b0;
      dec_e <= 1'b0;
      tgt_e <= '0;
    end else begin
      if (flush_dec_i) begin
        hit_d <= 1'b0;
        dec_d <= 1'b0;
      end else if (!stall_i) begin
        hit_d <= lk_hit_c;
        dec_d <= lk_hit_c & ram_lk_cnt[1];
      end
      if (!stall_i) tgt_d <= ram_lk_target;

      if (flush_exe_i) begin
        hit_e <= 1'b0;
        dec_e <= 1'b0;
      end else if (!stall_i) begin
        hit_e <= hit_d;
        dec_e <= dec_d;
      end
      if (!stall_i) tgt_e <= tgt_d;
    end
  end

  assign branch_hit_o      = hit_d;
  assign branch_decision_o = dec_d;
  assign branch_target_o   = tgt_d;

  assign branch_misprediction_o = exe_is_branch_i & hit_e &
                                  ((dec_e != exe_taken_i) |
                                   (exe_taken_i & (tgt_e != exe_target_i)));

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a small reference model predicts
// each lookup and Execute misprediction.
module tb_branch_target_buffer;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ENTRY_NUM = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            stall_i, flush_dec_i, flush_exe_i;
  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            exe_is_branch_i;
  logic [XLEN-1:0] exe_pc_i;
  logic            exe_taken_i;
  logic [XLEN-1:0] exe_target_i;
  logic            branch_hit_o, branch_decision_o, branch_misprediction_o;
  logic [XLEN-1:0] branch_target_o;

  branch_target_buffer #(.ENTRY_NUM(ENTRY_NUM), .XLEN(XLEN)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .stall_i                (stall_i),
    .flush_dec_i            (flush_dec_i),
    .flush_exe_i            (flush_exe_i),
    .pc_i                   (pc_i),
    .pc_valid_i             (pc_valid_i),
    .exe_is_branch_i        (exe_is_branch_i),
    .exe_pc_i               (exe_pc_i),
    .exe_taken_i            (exe_taken_i),
    .exe_target_i           (exe_target_i),
    .branch_hit_o           (branch_hit_o),
    .branch_decision_o      (branch_decision_o),
    .branch_target_o        (branch_target_o),
    .branch_misprediction_o (branch_misprediction_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic            hit;
    logic            dec;
    logic [XLEN-1:0] tgt;
  } pred_t;

  pred_t sb_q[$];

  bit          m_valid [ENTRY_NUM];
  logic [23:0] m_tag   [ENTRY_NUM];
  logic [31:0] m_tgt   [ENTRY_NUM];
  logic [1:0]  m_cnt   [ENTRY_NUM];

  int total = 0;
  int bad   = 0;

  function automatic pred_t predict(input logic [31:0] pc);
    pred_t p;
    int    i;
    i     = int'(pc[7:2]);
    p.hit = m_valid[i] && (m_tag[i] == pc[31:8]);
    p.dec = p.hit && m_cnt[i][1];
    p.tgt = m_tgt[i];
    return p;
  endfunction

  function automatic logic exp_misp(input pred_t e, input logic tk, input logic [31:0] tg);
    if (!e.hit) return 1'b0;
    return (e.dec != tk) || (tk && (e.tgt != tg));
  endfunction

  task automatic model_train(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    int i;
    i = int'(pc[7:2]);
    if (m_valid[i] && m_tag[i] == pc[31:8]) begin
      if (tk) begin
        m_cnt[i] = (m_cnt[i] == 2'd3) ? 2'd3 : m_cnt[i] + 2'd1;
        m_tgt[i] = tg;
      end else begin
        m_cnt[i] = (m_cnt[i] == 2'd0) ? 2'd0 : m_cnt[i] - 2'd1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:8];
      m_tgt[i]   = tg;
      m_cnt[i]   = 2'd2;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRY_NUM); i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; flush_dec_i = 0; flush_exe_i = 0;
    pc_i = '0; pc_valid_i = 0;
    exe_is_branch_i = 0; exe_pc_i = '0; exe_taken_i = 0; exe_target_i = '0;
  endtask

  task automatic do_train(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    exe_is_branch_i = 1; exe_pc_i = pc; exe_taken_i = tk; exe_target_i = tg;
    tick();
    model_train(pc, tk, tg);
    exe_is_branch_i = 0;
  endtask

  task automatic drive_lookup(input logic [31:0] pc);
    pc_i = pc; pc_valid_i = 1;
    sb_q.push_back(predict(pc));
    tick();
    pc_valid_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    pc_i = 32'h1000; pc_valid_i = 1;
    exe_is_branch_i = 1; exe_pc_i = 32'h1000;
    repeat (2) tick();
    total++;
    if ({branch_hit_o, branch_decision_o, branch_target_o, branch_misprediction_o} !== '0) begin
      bad++;
      $display("FAIL reset_held: hit=%0b dec=%0b tgt=%h misp=%0b expected all 0",
               branch_hit_o, branch_decision_o, branch_target_o, branch_misprediction_o);
    end
    idle_inputs();
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
    #1;
    total++;
    if ({branch_hit_o, branch_decision_o, branch_target_o, branch_misprediction_o} !== '0) begin
      bad++;
      $display("FAIL reset_release: hit=%0b dec=%0b tgt=%h misp=%0b expected all 0",
               branch_hit_o, branch_decision_o, branch_target_o, branch_misprediction_o);
    end
  endtask

  // Cold lookup misses; resolving it taken is not flagged and allocates the entry.
  task automatic test_cold_miss();
    pred_t e;
    drive_lookup(32'h1000);
    e = sb_q.pop_front();
    total++;
    if ({branch_hit_o, branch_decision_o} !== {e.hit, e.dec} || e.hit !== 1'b0) begin
      bad++;
      $display("FAIL cold_lookup: hit=%0b dec=%0b expected %0b %0b",
               branch_hit_o, branch_decision_o, e.hit, e.dec);
    end
    tick();
    exe_is_branch_i = 1; exe_pc_i = 32'h1000; exe_taken_i = 1; exe_target_i = 32'h2000;
    #1;
    total++;
    if (branch_misprediction_o !== 1'b0) begin
      bad++;
      $display("FAIL cold_miss_misp: misp=%0b expected 0", branch_misprediction_o);
    end
    tick();
    model_train(32'h1000, 1, 32'h2000);
    exe_is_branch_i = 0;
  endtask

  // Lookup/resolve sequences on 0x1000 walking the counter through saturation.
  task automatic test_counter();
    logic        tk_tab [10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [31:0] tg_tab [10] = '{32'h2000, 32'h2400, 32'h2400, 32'h2400, 32'h2400,
                                 32'h2400, 32'h2400, 32'h2400, 32'h2400, 32'h2400};
    pred_t e;
    logic  m;
    do_train(32'h1000, 1, 32'h2000);
    for (int s = 0; s < 10; s++) begin
      drive_lookup(32'h1000);
      e = sb_q.pop_front();
      total++;
      if ({branch_hit_o, branch_decision_o} !== {e.hit, e.dec} ||
          (e.hit && branch_target_o !== e.tgt)) begin
        bad++;
        $display("FAIL counter_lookup[%0d]: hit=%0b dec=%0b tgt=%h expected %0b %0b %h",
                 s, branch_hit_o, branch_decision_o, branch_target_o, e.hit, e.dec, e.tgt);
      end
      tick();
      exe_is_branch_i = 1; exe_pc_i = 32'h1000;
      exe_taken_i = tk_tab[s]; exe_target_i = tg_tab[s];
      #1;
      m = exp_misp(e, tk_tab[s], tg_tab[s]);
      total++;
      if (branch_misprediction_o !== m) begin
        bad++;
        $display("FAIL counter_misp[%0d]: misp=%0b expected %0b", s, branch_misprediction_o, m);
      end
      tick();
      model_train(32'h1000, tk_tab[s], tg_tab[s]);
      exe_is_branch_i = 0;
    end
  endtask

  task automatic test_alias();
    logic [31:0] pcs [2] = '{32'h1000, 32'h1100};
    pred_t e;
    do_train(32'h1000, 1, 32'h2000);
    do_train(32'h1100, 1, 32'h3000);
    for (int k = 0; k < 2; k++) begin
      pc_i = pcs[k]; pc_valid_i = 1;
      sb_q.push_back(predict(pcs[k]));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({branch_hit_o, branch_decision_o} !== {e.hit, e.dec} ||
          (e.hit && branch_target_o !== e.tgt)) begin
        bad++;
        $display("FAIL alias[%h]: hit=%0b dec=%0b tgt=%h expected %0b %0b %h",
                 pcs[k], branch_hit_o, branch_decision_o, branch_target_o, e.hit, e.dec, e.tgt);
      end
    end
    pc_valid_i = 0;
  endtask

  task automatic test_back_to_back();
    pred_t e;
    logic [31:0] pc;
    for (int k = 0; k < 8; k++) do_train(32'h40 + 32'(4 * k), 1, 32'h8000 + 32'(16 * k));
    for (int k = 0; k < 16; k++) begin
      pc = (k % 3 == 2) ? 32'h10040 + 32'(4 * (k % 8)) : 32'h40 + 32'(4 * (k % 8));
      pc_i = pc; pc_valid_i = 1;
      sb_q.push_back(predict(pc));
      tick();
      e = sb_q.pop_front();
      total++;
      if ({branch_hit_o, branch_decision_o} !== {e.hit, e.dec} ||
          (e.hit && branch_target_o !== e.tgt)) begin
        bad++;
        $display("FAIL b2b[%0d] pc=%h: hit=%0b dec=%0b tgt=%h expected %0b %0b %h",
                 k, pc, branch_hit_o, branch_decision_o, branch_target_o, e.hit, e.dec, e.tgt);
      end
    end
    pc_valid_i = 0;
  endtask

  task automatic test_stall_flush();
    pred_t e;
    drive_lookup(32'h1100);
    e = sb_q.pop_front();
    // Stall with a new PC and a taken branch for 0x1000 in Execute.
    stall_i = 1; pc_i = 32'h1000; pc_valid_i = 1;
    exe_is_branch_i = 1; exe_pc_i = 32'h1000; exe_taken_i = 1; exe_target_i = 32'h4000;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({branch_hit_o, branch_decision_o, branch_target_o} !== {e.hit, e.dec, e.tgt} ||
          e.hit !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: hit=%0b dec=%0b tgt=%h expected %0b %0b %h",
                 c, branch_hit_o, branch_decision_o, branch_target_o, e.hit, e.dec, e.tgt);
      end
    end
    stall_i = 0; exe_is_branch_i = 0; pc_valid_i = 0;
    drive_lookup(32'h1000);
    e = sb_q.pop_front();
    total++;
    if ({branch_hit_o, branch_decision_o} !== {e.hit, e.dec}) begin
      bad++;
      $display("FAIL stall_no_train: hit=%0b dec=%0b expected %0b %0b",
               branch_hit_o, branch_decision_o, e.hit, e.dec);
    end
    for (int f = 0; f < 2; f++) begin
      drive_lookup(32'h1100);
      void'(sb_q.pop_front());
      flush_dec_i = 1; stall_i = (f == 1);
      tick();
      flush_dec_i = 0; stall_i = 0;
      total++;
      if ({branch_hit_o, branch_decision_o} !== 2'b00) begin
        bad++;
        $display("FAIL flush_dec[stall=%0d]: hit=%0b dec=%0b expected 0 0",
                 f, branch_hit_o, branch_decision_o);
      end
    end
    // Execute flush drops a hit that would otherwise mispredict a not-taken.
    drive_lookup(32'h1100);
    e = sb_q.pop_front();
    flush_exe_i = 1;
    tick();
    flush_exe_i = 0;
    exe_is_branch_i = 1; exe_pc_i = 32'h1100; exe_taken_i = 0; exe_target_i = 32'h3000;
    #1;
    total++;
    if (branch_misprediction_o !== 1'b0 || e.dec !== 1'b1) begin
      bad++;
      $display("FAIL flush_exe: misp=%0b expected 0 (pred dec=%0b)", branch_misprediction_o, e.dec);
    end
    tick();
    model_train(32'h1100, 0, 32'h3000);
    exe_is_branch_i = 0;
  endtask

  task automatic test_same_cycle();
    pred_t e;
    rst_i = 1;
    tick();
    rst_i = 0;
    model_reset();
    pc_i = 32'h1000; pc_valid_i = 1;
    exe_is_branch_i = 1; exe_pc_i = 32'h1000; exe_taken_i = 1; exe_target_i = 32'h2000;
    sb_q.push_back(predict(32'h1000));
    tick();
    model_train(32'h1000, 1, 32'h2000);
    exe_is_branch_i = 0; pc_valid_i = 0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) drive_lookup(32'h1000);
      e = sb_q.pop_front();
      total++;
      if ({branch_hit_o, branch_decision_o} !== {e.hit, e.dec} ||
          (e.hit && branch_target_o !== e.tgt) || e.hit !== 1'(k)) begin
        bad++;
        $display("FAIL same_cycle[%0d]: hit=%0b dec=%0b tgt=%h expected %0b %0b %h",
                 k, branch_hit_o, branch_decision_o, branch_target_o, e.hit, e.dec, e.tgt);
      end
    end
  endtask

  task automatic test_async_reset();
    pred_t e;
    do_train(32'h1100, 1, 32'h3000);
    drive_lookup(32'h1000);
    void'(sb_q.pop_front());
    @(negedge clk_i);
    #2;
    rst_i = 1;
    exe_is_branch_i = 1; exe_pc_i = 32'h1000; exe_taken_i = 0;
    #1;
    total++;
    if ({branch_hit_o, branch_decision_o, branch_target_o, branch_misprediction_o} !== '0) begin
      bad++;
      $display("FAIL async_reset: hit=%0b dec=%0b tgt=%h misp=%0b expected all 0",
               branch_hit_o, branch_decision_o, branch_target_o, branch_misprediction_o);
    end
    exe_is_branch_i = 0;
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
    drive_lookup(32'h1000);
    drive_lookup(32'h1100);
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      total++;
      if (e.hit !== 1'b0 || (k == 1 && branch_hit_o !== 1'b0)) begin
        bad++;
        $display("FAIL post_reset_miss[%0d]: hit=%0b expected 0", k, branch_hit_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_counter();
    test_alias();
    test_back_to_back();
    test_stall_flush();
    test_same_cycle();
    test_async_reset();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
